fe_uop_queue: RTL and testbench
===============================

Name: fe_uop_queue

Overview:
- Receiving end of the front-end decoded-instruction valid/ready interface: the consumer of the fe_valid/fe_ready/fe_pc/rs1/rs2/rd/imm/control-bit stream.
- Buffers decoded micro-ops in a first-word-fall-through FIFO and presents them to rename/dispatch over a second valid/ready interface.
- Decouples front-end timing from back-end stalls (ROB full, RS full).
- Discards all buffered micro-ops on a branch-mispredict flush.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- XLEN, 32, width of pc and imm.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid_i  input  1  front-end micro-op valid (driven from fe_valid).
- in_ready_o  output  1  queue can accept (drives fe_ready).
- in_uop_i  input  UOP_W  packed fe_uop_t: pc, rs1, rs2, rd, imm, ALUSrc, ALUOp[2:0], branch, jump, MemRead, MemWrite, RegWrite, MemToReg. UOP_W is 89 when XLEN=32.
- out_valid_o  output  1  head entry valid to dispatch.
- out_ready_i  input  1  dispatch accepts the head entry.
- out_uop_o  output  UOP_W  head entry contents.
- flush_i  input  1  mispredict flush, single-cycle pulse.
- count_o  output  CNT_W  current occupancy.
- full_o  output  1  count_o == DEPTH.
- empty_o  output  1  count_o == 0.
- stall_cnt_o  output  16  saturating count of cycles with in_valid_i=1 and in_ready_o=0.

Behaviour:
- Reset (reset=0, asynchronous):
  - head, tail and count are 0; stall_cnt_o is 0.
  - out_valid_o=0, full_o=0, empty_o=1.
  - in_ready_o is forced to 0 while reset is low; it becomes 1 in the first cycle after reset deasserts.
  - Entry storage is not reset. out_uop_o is don't-care while out_valid_o=0.
- Flow control:
  - in_ready_o = !full_o. It depends only on registered state; there is no combinational path from out_ready_i.
  - out_valid_o = !empty_o.
- Transfers:
  - push = in_valid_i & in_ready_o & !flush_i.
  - pop = out_valid_o & out_ready_i & !flush_i.
  - Push writes mem[tail]; tail advances modulo DEPTH.
  - Pop advances head modulo DEPTH.
- Count update:
  - push only: count+1. Pop only: count-1. Both or neither: count unchanged.
  - Simultaneous push and pop is legal at any non-full, non-empty count.
  - When full, push is blocked even if a pop occurs that cycle. Bubble-free full throughput is not required.
- Latency: first-word-fall-through. A micro-op pushed in cycle N appears on out_uop_o with out_valid_o=1 in cycle N+1 when the queue was empty. There is no same-cycle bypass.
- Ordering: strict FIFO order; no entry is dropped or duplicated except by flush.
- Flush (flush_i=1 at a clock edge):
  - head, tail and count go to 0 on the next edge.
  - Any push or pop in the flush cycle is ignored.
  - out_valid_o=0 in the cycle after the flush.
  - Flush has priority over all other activity.
- Pointer wrap: head and tail are $clog2(DEPTH) bits and wrap naturally. Full and empty are taken from count, not from pointer comparison.
- stall_cnt_o: increments by 1 in each cycle where in_valid_i & !in_ready_o. It saturates at 16'hFFFF, is not cleared by flush, and is cleared only by reset.
- Stability: while out_valid_o=1 and out_ready_i=0, out_uop_o holds stable.
- Upstream rule: the sender holds in_uop_i stable while in_valid_i=1 and in_ready_o=0. The queue does not check this.

Decomposition:
- Shared package fe_pkg:
  - fe_uop_t packed struct.
  - Localparams UOP_W and ALUOP_W=3.
  - REG_IDX_W=5.
- One sub-module: fe_uop_queue_mem, a DEPTH x UOP_W register array with one write port and one asynchronous read port. Pointer, count and handshake logic stay in the top module.

Test Plan:
- Reset then idle: hold reset=0 for 4 cycles, then release. Required: in_ready_o=0 during reset, 1 in the first cycle after release; empty_o=1; count_o=0; out_valid_o=0.
- Fill with out_ready_i=0: push 8 micro-ops with pc 0x0,0x4,...,0x1C. Required: count_o reaches 8, full_o=1, in_ready_o=0. Holding in_valid_i for 5 more cycles gives stall_cnt_o=5.
- Drain: from full, set out_ready_i=1. Required: pc 0x0 through 0x1C emerge in order on 8 consecutive cycles, then empty_o=1.
- Streaming: in_valid_i=1 and out_ready_i=1 continuously for 20 cycles after a single prefill. Required: count_o stays 1; pc values emerge in order with no gaps; head and tail wrap past 7 at least twice.
- Flush: at count_o=5, assert flush_i together with in_valid_i=1 and out_ready_i=1. Required: next cycle count_o=0, out_valid_o=0, and the pushed micro-op does not appear later.
- Async reset mid-operation: at count_o=3, drop reset between clock edges. Required: count_o=0 and out_valid_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fe_uop_queue_pkg.sv
// Shared front-end micro-op types: the decoded instruction record carried
// from decode to rename/dispatch, plus its field widths.
package fe_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int ALUOP_W   = 3;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      imm;
    logic                 ALUSrc;
    logic [ALUOP_W-1:0]   ALUOp;
    logic                 branch;
    logic                 jump;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 RegWrite;
    logic                 MemToReg;
  } fe_uop_t;

  // 89 bits at XLEN=32
  localparam int UOP_W = $bits(fe_uop_t);

endpackage

// File: rtl/fe_uop_queue_if.sv
// Bundle of the queue's upstream (front-end) and downstream (dispatch)
// valid/ready channels plus flush and status. The queue sits on the slave
// side; whoever drives the front end and dispatch sits on the master side.
interface fe_uop_queue_if
  import fe_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic             in_valid_i;
  logic             in_ready_o;
  fe_uop_t          in_uop_i;
  logic             out_valid_o;
  logic             out_ready_i;
  fe_uop_t          out_uop_o;
  logic             flush_i;
  logic [CNT_W-1:0] count_o;
  logic             full_o;
  logic             empty_o;
  logic [15:0]      stall_cnt_o;

  modport slave (
    input  in_valid_i, in_uop_i, out_ready_i, flush_i,
    output in_ready_o, out_valid_o, out_uop_o, count_o, full_o, empty_o,
           stall_cnt_o
  );

  modport master (
    output in_valid_i, in_uop_i, out_ready_i, flush_i,
    input  in_ready_o, out_valid_o, out_uop_o, count_o, full_o, empty_o,
           stall_cnt_o
  );
endinterface

// File: rtl/fe_uop_queue_mem.sv
// Entry storage for the micro-op queue: one synchronous write port and one
// asynchronous read port so the head entry falls through combinationally.
// Storage is deliberately not reset; validity is tracked by the count.
module fe_uop_queue_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 89,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  // write the pushed entry at the tail slot
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fe_uop_queue.sv
// Decoded micro-op queue between the front end and rename/dispatch.
// First-word-fall-through FIFO: a push becomes visible at the head one cycle
// later. All handshake outputs are registered so front-end ready never
// depends combinationally on back-end ready. A mispredict flush empties the
// queue and overrides any push or pop in the same cycle.
module fe_uop_queue
  import fe_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           reset,
  fe_uop_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 2*XLEN + 3*REG_IDX_W + ALUOP_W + 7;

  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_in_rdy;
  logic             r_out_vld;
  logic             r_full;
  logic [15:0]      r_stall;
  logic             w_push, w_pop;
  logic [ENT_W-1:0] w_rdata;

  assign w_push = bus.in_valid_i & r_in_rdy  & ~bus.flush_i;
  assign w_pop  = r_out_vld & bus.out_ready_i & ~bus.flush_i;

  // next occupancy: flush wins, simultaneous push+pop leaves it unchanged
  always_comb begin
    w_cnt_nxt = r_count;
    if (bus.flush_i)          w_cnt_nxt = '0;
    else if (w_push & ~w_pop) w_cnt_nxt = r_count + CNT_W'(1);
    else if (w_pop & ~w_push) w_cnt_nxt = r_count - CNT_W'(1);
  end

  // pointers, count and registered status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_in_rdy  <= 1'b0;
      r_out_vld <= 1'b0;
      r_full    <= 1'b0;
    end else begin
      if (bus.flush_i) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + PTR_W'(1);
        if (w_pop)  r_head <= r_head + PTR_W'(1);
      end
      r_count   <= w_cnt_nxt;
      r_full    <= (w_cnt_nxt == CNT_W'(DEPTH));
      r_in_rdy  <= (w_cnt_nxt != CNT_W'(DEPTH));
      r_out_vld <= (w_cnt_nxt != '0);
    end
  end

  // saturating count of cycles where the front end was held off
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall <= '0;
    else if (bus.in_valid_i && !r_in_rdy && r_stall != 16'hFFFF)
      r_stall <= r_stall + 16'd1;
  end

  fe_uop_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_tail),
    .i_wdata (bus.in_uop_i),
    .i_raddr (r_head),
    .o_rdata (w_rdata)
  );

  assign bus.in_ready_o  = r_in_rdy;
  assign bus.out_valid_o = r_out_vld;
  assign bus.out_uop_o   = w_rdata;
  assign bus.count_o     = r_count;
  assign bus.full_o      = r_full;
  assign bus.empty_o     = ~r_out_vld;
  assign bus.stall_cnt_o = r_stall;
endmodule

// File: tb/tb_fe_uop_queue.sv
// Bench for fe_uop_queue: directed phases from the test plan followed by a
// random phase, all compared against a queue-based reference model.
module tb_fe_uop_queue;
  import fe_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fe_uop_queue_if #(.DEPTH(DEPTH)) bus ();

  fe_uop_queue #(.DEPTH(DEPTH), .XLEN(32), .CNT_W($clog2(DEPTH)+1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // reference model state
  fe_uop_t     q[$];
  bit          m_live;
  logic [15:0] m_stall;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready",  128'(bus.in_ready_o),  128'(m_live && q.size() < DEPTH));
    chk("out_valid", 128'(bus.out_valid_o), 128'(q.size() != 0));
    chk("count",     128'(bus.count_o),     128'(q.size()));
    chk("full",      128'(bus.full_o),      128'(q.size() == DEPTH));
    chk("empty",     128'(bus.empty_o),     128'(q.size() == 0));
    chk("stall_cnt", 128'(bus.stall_cnt_o), 128'(m_stall));
    if (q.size() != 0) chk("head_uop", 128'(bus.out_uop_o), 128'(q[0]));
  endtask

  function automatic fe_uop_t mk_uop(input logic [31:0] pc);
    logic [95:0] r;
    fe_uop_t u;
    r = {$urandom(), $urandom(), $urandom()};
    u = r[UOP_W-1:0];
    u.pc = pc;
    return u;
  endfunction

  // one clock cycle: check outputs, drive inputs, advance DUT and model
  task automatic cyc(input logic v, input fe_uop_t u, input logic rdy, input logic fl);
    bit ready, push, pop;
    check_all();
    bus.in_valid_i  = v;
    bus.in_uop_i    = u;
    bus.out_ready_i = rdy;
    bus.flush_i     = fl;
    ready = m_live && q.size() < DEPTH;
    push  = v && ready && !fl;
    pop   = (q.size() != 0) && rdy && !fl;
    if (v && !ready && m_stall != 16'hFFFF) m_stall++;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(u);
    end
    m_live = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.in_valid_i  = 1'b0;
    bus.in_uop_i    = '0;
    bus.out_ready_i = 1'b0;
    bus.flush_i     = 1'b0;
  endtask

  // hold reset for 4 cycles checking forced-off outputs, release at negedge
  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    q.delete();
    m_live  = 1'b0;
    m_stall = '0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_in_ready",  128'(bus.in_ready_o),  128'(0));
      chk("rst_count",     128'(bus.count_o),     128'(0));
      chk("rst_empty",     128'(bus.empty_o),     128'(1));
      chk("rst_out_valid", 128'(bus.out_valid_o), 128'(0));
    end
    reset = 1'b1;
    // first cycle after release: ready comes up at the next edge
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("post_rst_ready", 128'(bus.in_ready_o), 128'(1));
  endtask

  initial begin
    fe_uop_t u;
    logic [31:0] pc;
    idle_inputs();
    do_reset();

    // fill with dispatch stalled
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, mk_uop(32'(i*4)), 1'b0, 1'b0);
    chk("fill_count", 128'(bus.count_o), 128'(8));
    chk("fill_full",  128'(bus.full_o),  128'(1));
    chk("fill_ready", 128'(bus.in_ready_o), 128'(0));
    u = mk_uop(32'h100);
    repeat (5) cyc(1'b1, u, 1'b0, 1'b0);
    chk("fill_stall", 128'(bus.stall_cnt_o), 128'(5));

    // drain in order on consecutive cycles
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_pc", 128'(bus.out_uop_o.pc), 128'(i*4));
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk("drain_empty", 128'(bus.empty_o), 128'(1));

    // streaming: one prefill then 20 cycles of simultaneous push/pop
    cyc(1'b1, mk_uop(32'h1000), 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      chk("stream_count", 128'(bus.count_o), 128'(1));
      chk("stream_pc", 128'(bus.out_uop_o.pc), 128'(32'h1000 + (i-1)*4));
      cyc(1'b1, mk_uop(32'(32'h1000 + i*4)), 1'b1, 1'b0);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);

    // flush at count 5 with push and pop both requested
    for (int i = 0; i < 5; i++) cyc(1'b1, mk_uop(32'(32'h2000 + i*4)), 1'b0, 1'b0);
    chk("pre_flush_count", 128'(bus.count_o), 128'(5));
    cyc(1'b1, mk_uop(32'hDEAD), 1'b1, 1'b1);
    chk("flush_count", 128'(bus.count_o),     128'(0));
    chk("flush_valid", 128'(bus.out_valid_o), 128'(0));
    cyc(1'b1, mk_uop(32'h3000), 1'b0, 1'b0);
    chk("post_flush_pc", 128'(bus.out_uop_o.pc), 128'(32'h3000));
    cyc(1'b0, '0, 1'b1, 1'b0);

    // random traffic
    pc = 32'h4000;
    for (int i = 0; i < 300; i++) begin
      u = mk_uop(pc);
      pc += 4;
      cyc(1'($urandom_range(0, 3) != 0), u, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) == 0));
    end
    repeat (DEPTH + 1) cyc(1'b0, '0, 1'b1, 1'b0);

    // async reset mid-operation at count 3
    for (int i = 0; i < 3; i++) cyc(1'b1, mk_uop(32'(32'h5000 + i*4)), 1'b0, 1'b0);
    chk("pre_arst_count", 128'(bus.count_o), 128'(3));
    #2 reset = 1'b0;
    #1;
    chk("arst_count", 128'(bus.count_o),     128'(0));
    chk("arst_valid", 128'(bus.out_valid_o), 128'(0));
    chk("arst_stall", 128'(bus.stall_cnt_o), 128'(0));
    do_reset();
    cyc(1'b1, mk_uop(32'h6000), 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
